ea_sequencer: RTL and testbench

- Sequences the 8088 effective-address computation for one ModR/M byte.
- Latches mod/RM, fetches 0, 1 or 2 displacement bytes from the prefetch byte stream, and selects base/index registers from the register bank.
- Computes EA = base + index + disp (mod 2^16) and hands EA plus the default segment to the bus-interface unit over a valid/ready handshake.
- Sits between the instruction decoder, the prefetch queue and the register bank's execution interface.

---
 rtl/ea_pkg.sv | 38 +++
 rtl/ea_modrm_decode.sv | 45 ++++
 rtl/ea_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ea_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ea_pkg.sv
// Shared types and constants for the 8088 effective-address sequencer.
// Holds the FSM states, operand-select encodings and ModR/M field constants.
package ea_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    CALC,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    BASE_NONE = 2'd0,
    BASE_BX   = 2'd1,
    BASE_BP   = 2'd2
  } base_e;

  typedef enum logic [1:0] {
    IDX_NONE = 2'd0,
    IDX_SI   = 2'd1,
    IDX_DI   = 2'd2
  } idx_e;

  typedef enum logic [1:0] {
    DISP_0  = 2'd0,
    DISP_8  = 2'd1,
    DISP_16 = 2'd2
  } disp_e;

  localparam logic [1:0] MOD_REG   = 2'b11;
  localparam logic [2:0] RM_DIRECT = 3'b110;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/ea_modrm_decode.sv
// Combinational ModR/M decode: picks base/index registers, displacement length
// and the default segment for one mod/rm pair.
module ea_modrm_decode
  import ea_pkg::*;
(
  input  logic [1:0] mod_i,
  input  logic [2:0] rm_i,
  output logic [1:0] base_o,
  output logic [1:0] idx_o,
  output logic [1:0] disp_len_o,
  output logic       seg_ss_o,
  output logic       reg_mode_o
);

  always_comb begin
    base_o     = BASE_NONE;
    idx_o      = IDX_NONE;
    disp_len_o = DISP_0;
    reg_mode_o = 1'b0;
    if (mod_i == MOD_REG) begin
      reg_mode_o = 1'b1;
    end else begin
      case (rm_i)
        3'b000, 3'b001, 3'b111: base_o = BASE_BX;
        3'b010, 3'b011:         base_o = BASE_BP;
        RM_DIRECT:              base_o = (mod_i != 2'b00) ? BASE_BP : BASE_NONE;
        default:                base_o = BASE_NONE;
      endcase
      case (rm_i)
        3'b000, 3'b010, 3'b100: idx_o = IDX_SI;
        3'b001, 3'b011, 3'b101: idx_o = IDX_DI;
        default:                idx_o = IDX_NONE;
      endcase
      // mod 00 with rm 110 is the direct-address form carrying a disp16
      case (mod_i)
        2'b01:   disp_len_o = DISP_8;
        2'b10:   disp_len_o = DISP_16;
        default: disp_len_o = (rm_i == RM_DIRECT) ? DISP_16 : DISP_0;
      endcase
    end
  end

  assign seg_ss_o = (base_o == BASE_BP);

endmodule

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: latches ModR/M, pulls 0-2 displacement bytes,
// adds base + index + disp and offers EA with its default segment.
module ea_sequencer
  import ea_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mod,
  input  logic [2:0]        rm,
  input  logic              abort,
  input  logic              disp_valid,
  input  logic [7:0]        disp_data,
  output logic              disp_ready,
  input  logic [ADDR_W-1:0] bx,
  input  logic [ADDR_W-1:0] bp,
  input  logic [ADDR_W-1:0] si,
  input  logic [ADDR_W-1:0] di,
  output logic              busy,
  output logic              ea_valid,
  input  logic              ea_ready,
  output logic [ADDR_W-1:0] ea,
  output logic              seg_ss,
  output logic              reg_mode
);

  state_e            state_q, state_d;
  logic [1:0]        base_q, base_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        len_q, len_d;
  logic              pseg_q, pseg_d;
  logic [ADDR_W-1:0] disp_q, disp_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic              seg_q, seg_d;
  logic              regm_q, regm_d;

  logic [1:0]        dec_base, dec_idx, dec_len;
  logic              dec_seg, dec_regm;
  logic [ADDR_W-1:0] base_val, idx_val;

  ea_modrm_decode u_decode (
    .mod_i      (mod),
    .rm_i       (rm),
    .base_o     (dec_base),
    .idx_o      (dec_idx),
    .disp_len_o (dec_len),
    .seg_ss_o   (dec_seg),
    .reg_mode_o (dec_regm)
  );

  assign busy       = (state_q != IDLE);
  assign ea_valid   = (state_q == RESP);
  assign disp_ready = !abort && ((state_q == FETCH_LO) || (state_q == FETCH_HI));
  assign ea         = ea_q;
  assign seg_ss     = seg_q;
  assign reg_mode   = regm_q;

  always_comb begin
    base_val = '0;
    idx_val  = '0;
    case (base_q)
      BASE_BX: base_val = bx;
      BASE_BP: base_val = bp;
      default: base_val = '0;
    endcase
    case (idx_q)
      IDX_SI:  idx_val = si;
      IDX_DI:  idx_val = di;
      default: idx_val = '0;
    endcase
  end

  // abort overrides every transition and clears the result outputs
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pseg_d  = pseg_q;
    disp_d  = disp_q;
    ea_d    = ea_q;
    seg_d   = seg_q;
    regm_d  = regm_q;
    if (abort) begin
      state_d = IDLE;
      ea_d    = '0;
      seg_d   = 1'b0;
      regm_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_d = dec_base;
            idx_d  = dec_idx;
            len_d  = dec_len;
            pseg_d = dec_seg;
            disp_d = '0;
            ea_d   = '0;
            seg_d  = 1'b0;
            regm_d = dec_regm;
            if (dec_regm)              state_d = RESP;
            else if (dec_len == DISP_0) state_d = CALC;
            else                        state_d = FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (disp_valid) begin
            if (len_q == DISP_8) begin
              disp_d  = sext8(disp_data);
              state_d = CALC;
            end else begin
              disp_d  = {disp_q[ADDR_W-1:8], disp_data};
              state_d = FETCH_HI;
            end
          end
        end
        FETCH_HI: begin
          if (disp_valid) begin
            disp_d  = {disp_data, disp_q[7:0]};
            state_d = CALC;
          end
        end
        CALC: begin
          ea_d    = base_val + idx_val + disp_q;
          seg_d   = pseg_q;
          state_d = RESP;
        end
        RESP: begin
          if (ea_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= BASE_NONE;
      idx_q   <= IDX_NONE;
      len_q   <= DISP_0;
      pseg_q  <= 1'b0;
      disp_q  <= '0;
      ea_q    <= '0;
      seg_q   <= 1'b0;
      regm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pseg_q  <= pseg_d;
      disp_q  <= disp_d;
      ea_q    <= ea_d;
      seg_q   <= seg_d;
      regm_q  <= regm_d;
    end
  end

endmodule

// File: tb/tb_ea_sequencer.sv
// Self-checking bench for ea_sequencer: directed ModR/M cases, randomized
// transactions against an 8086 addressing-table model, abort and reset cases.
module tb_ea_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mod = 2'b00;
  logic [2:0]  rm = 3'b000;
  logic        abort = 1'b0;
  logic        disp_valid = 1'b0;
  logic [7:0]  disp_data = 8'h00;
  logic        disp_ready;
  logic [15:0] bx = 16'h0, bp = 16'h0, si = 16'h0, di = 16'h0;
  logic        busy, ea_valid, seg_ss, reg_mode;
  logic        ea_ready = 1'b0;
  logic [15:0] ea;

  int nAsserts = 0;
  int nFails = 0;
  bit randRegs = 1'b0;

  ea_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mod(mod), .rm(rm), .abort(abort),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
    .bx(bx), .bp(bp), .si(si), .di(di), .busy(busy), .ea_valid(ea_valid),
    .ea_ready(ea_ready), .ea(ea), .seg_ss(seg_ss), .reg_mode(reg_mode)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 8086 addressing table: [BX+SI] [BX+DI] [BP+SI] [BP+DI] [SI] [DI] [BP]/disp16 [BX]
  function automatic logic [15:0] refEa(input logic [1:0] m, input logic [2:0] r,
                                        input logic [15:0] vbx, input logic [15:0] vbp,
                                        input logic [15:0] vsi, input logic [15:0] vdi,
                                        input logic [15:0] d);
    int sum;
    if (m == 2'b11) return 16'h0000;
    case (r)
      3'd0: sum = int'(vbx) + int'(vsi);
      3'd1: sum = int'(vbx) + int'(vdi);
      3'd2: sum = int'(vbp) + int'(vsi);
      3'd3: sum = int'(vbp) + int'(vdi);
      3'd4: sum = int'(vsi);
      3'd5: sum = int'(vdi);
      3'd6: sum = (m == 2'b00) ? 0 : int'(vbp);
      default: sum = int'(vbx);
    endcase
    if (m == 2'b01) sum = sum + int'($signed(d[7:0]));
    else if (m == 2'b10 || (m == 2'b00 && r == 3'd6)) sum = sum + int'(d);
    return sum[15:0];
  endfunction

  function automatic logic refSeg(input logic [1:0] m, input logic [2:0] r);
    return (m != 2'b11) && (r == 3'd2 || r == 3'd3 || (r == 3'd6 && m != 2'b00));
  endfunction

  function automatic int refBytes(input logic [1:0] m, input logic [2:0] r);
    if (m == 2'b01) return 1;
    if (m == 2'b10 || (m == 2'b00 && r == 3'd6)) return 2;
    return 0;
  endfunction

  // One full transaction; stall < 0 picks a random 0..2 stall before each byte
  task automatic applyStimulus(input string tag, input logic [1:0] m, input logic [2:0] r,
                               input logic [15:0] d, input int stall, input int holdCycles,
                               input bit pokeStart);
    int nb, sent, cycles, stallLeft, stallTotal, expLat;
    bit offered;
    logic [15:0] sbx, sbp, ssi, sdi, expEa;
    nb = refBytes(m, r);
    sent = 0; cycles = 0; stallTotal = 0;
    sbx = bx; sbp = bp; ssi = si; sdi = di;
    mod = m; rm = r; start = 1'b1;
    tick();
    start = 1'b0;
    stallLeft = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
    while (!ea_valid && cycles < 40) begin
      if (randRegs) begin
        bx = 16'($urandom); bp = 16'($urandom); si = 16'($urandom); di = 16'($urandom);
      end
      sbx = bx; sbp = bp; ssi = si; sdi = di;
      offered = 1'b0;
      if (disp_ready) begin
        if (stallLeft > 0) begin
          disp_valid = 1'b0;
          stallLeft--;
          stallTotal++;
        end else begin
          disp_valid = 1'b1;
          disp_data = (sent == 0) ? d[7:0] : d[15:8];
          offered = 1'b1;
        end
      end else begin
        disp_valid = 1'b0;
      end
      tick();
      if (offered) begin
        sent++;
        stallLeft = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      end
      cycles++;
    end
    disp_valid = 1'b0;
    expLat = (m == 2'b11) ? 0 : nb + 1 + stallTotal;
    expEa = refEa(m, r, sbx, sbp, ssi, sdi, d);
    checkOutput({tag, ".latency"}, cycles, expLat);
    checkOutput({tag, ".bytes"}, sent, nb);
    checkOutput({tag, ".ea"}, ea, expEa);
    checkOutput({tag, ".seg_ss"}, seg_ss, refSeg(m, r));
    checkOutput({tag, ".reg_mode"}, reg_mode, (m == 2'b11));
    checkOutput({tag, ".busy"}, busy, 1);
    for (int i = 0; i < holdCycles; i++) begin
      if (pokeStart) begin
        start = 1'b1; mod = 2'b00; rm = 3'b100;
      end
      if (randRegs) begin
        bx = 16'($urandom); bp = 16'($urandom); si = 16'($urandom); di = 16'($urandom);
      end
      tick();
      start = 1'b0;
      checkOutput({tag, ".hold_valid"}, ea_valid, 1);
      checkOutput({tag, ".hold_ea"}, ea, expEa);
    end
    ea_ready = 1'b1;
    tick();
    ea_ready = 1'b0;
    checkOutput({tag, ".done_valid"}, ea_valid, 0);
    checkOutput({tag, ".done_busy"}, busy, 0);
  endtask

  initial begin
    logic [1:0] rm2;
    logic [2:0] rr;
    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.disp_ready", disp_ready, 0);
    checkOutput("reset.ea_valid", ea_valid, 0);
    checkOutput("reset.seg_ss", seg_ss, 0);
    checkOutput("reset.reg_mode", reg_mode, 0);
    checkOutput("reset.ea", ea, 0);
    rst_n = 1'b1;
    tick();

    // Directed plan cases
    bx = 16'h1000; si = 16'h0234;
    applyStimulus("t1_bx_si", 2'b00, 3'b000, 16'h0000, 0, 0, 1'b0);
    bp = 16'h2000; di = 16'h0010;
    applyStimulus("t2_disp8_stall", 2'b01, 3'b011, 16'h00F0, 2, 1, 1'b0);
    applyStimulus("t3_direct", 2'b00, 3'b110, 16'h1234, 0, 0, 1'b0);
    bx = 16'hFFFF;
    applyStimulus("t4_wrap", 2'b10, 3'b111, 16'h0002, 0, 3, 1'b1);
    applyStimulus("t5_regmode", 2'b11, 3'b101, 16'h0000, 0, 1, 1'b0);

    // Abort in FETCH_HI with a byte presented
    mod = 2'b10; rm = 3'b000; start = 1'b1;
    tick();
    start = 1'b0;
    disp_valid = 1'b1; disp_data = 8'h11;
    tick();
    checkOutput("abortHi.pre_ready", disp_ready, 1);
    disp_data = 8'h22; abort = 1'b1;
    #1;
    checkOutput("abortHi.disp_ready", disp_ready, 0);
    tick();
    abort = 1'b0; disp_valid = 1'b0;
    checkOutput("abortHi.busy", busy, 0);
    checkOutput("abortHi.ea_valid", ea_valid, 0);
    checkOutput("abortHi.ea", ea, 0);
    checkOutput("abortHi.disp_ready", disp_ready, 0);
    bx = 16'h0100; si = 16'h0001;
    applyStimulus("t6_after_abort", 2'b10, 3'b000, 16'h3000, 0, 0, 1'b0);

    // Reset in CALC
    bp = 16'h4000; si = 16'h0005;
    mod = 2'b00; rm = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("rstCalc.pre_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rstCalc.busy", busy, 0);
    checkOutput("rstCalc.ea_valid", ea_valid, 0);
    checkOutput("rstCalc.ea", ea, 0);
    checkOutput("rstCalc.seg_ss", seg_ss, 0);
    tick();
    checkOutput("rstCalc.stays_idle", ea_valid, 0);

    // Abort with start in IDLE drops the start
    start = 1'b1; abort = 1'b1; mod = 2'b00; rm = 3'b100;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("abortStart.busy", busy, 0);
    tick();
    checkOutput("abortStart.ea_valid", ea_valid, 0);

    // ea_ready together with abort in RESP
    bx = 16'h0055;
    mod = 2'b00; rm = 3'b111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checkOutput("abortResp.valid", ea_valid, 1);
    checkOutput("abortResp.ea", ea, 16'h0055);
    ea_ready = 1'b1; abort = 1'b1;
    tick();
    ea_ready = 1'b0; abort = 1'b0;
    checkOutput("abortResp.cleared_valid", ea_valid, 0);
    checkOutput("abortResp.cleared_ea", ea, 0);
    checkOutput("abortResp.busy", busy, 0);

    // Randomized transactions
    randRegs = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rm2 = 2'($urandom_range(0, 3));
      rr = 3'($urandom_range(0, 7));
      applyStimulus($sformatf("rand%0d", k), rm2, rr, 16'($urandom),
                    -1, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
